// File: rtl/urv_defs.sv
// rtl/urv_defs.sv - shared writeback FSM states, load function codes and result-source selectors
package urv_defs;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_LOAD  = 2'd1,
    ST_WAIT_STORE = 2'd2
  } wb_state_t;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam logic [1:0] RD_SOURCE_ALU      = 2'd0;
  localparam logic [1:0] RD_SOURCE_LOAD     = 2'd1;
  localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'd2;
  localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'd3;

endpackage

// File: rtl/urv_writeback_if.sv
// rtl/urv_writeback_if.sv - exec-stage to writeback instruction bundle
interface urv_writeback_if;
  logic        valid;
  logic        load;
  logic        store;
  logic        rd_write;
  logic [2:0]  fun;
  logic [4:0]  rd;
  logic [1:0]  rd_source;
  logic [31:0] dm_addr;
  logic [31:0] rd_value;
  logic [31:0] rd_shifter;
  logic [31:0] rd_multiply;

  modport master (
    output valid, load, store, rd_write, fun, rd, rd_source,
    output dm_addr, rd_value, rd_shifter, rd_multiply
  );

  modport slave (
    input valid, load, store, rd_write, fun, rd, rd_source,
    input dm_addr, rd_value, rd_shifter, rd_multiply
  );
endinterface

// File: rtl/urv_load_align.sv
// rtl/urv_load_align.sv - selects the addressed byte/halfword/word of load data and extends it
module urv_load_align
  import urv_defs::*;
(
  input  logic [2:0]  fun,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    case (addr)
      2'd0:    lane_b = data[7:0];
      2'd1:    lane_b = data[15:8];
      2'd2:    lane_b = data[23:16];
      default: lane_b = data[31:24];
    endcase
    lane_h = addr[1] ? data[31:16] : data[15:0];
  end

  always_comb begin
    value = '0;
    case (fun)
      LDST_B:  value = {{24{lane_b[7]}}, lane_b};
      LDST_BU: value = {24'h0, lane_b};
      LDST_H:  value = {{16{lane_h[15]}}, lane_h};
      LDST_HU: value = {16'h0, lane_h};
      LDST_W:  value = data;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/urv_writeback.sv
// rtl/urv_writeback.sv - writeback stage: load/store completion FSM and registered register-file write port
module urv_writeback
  import urv_defs::*;
#(
  parameter int g_with_multiply = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_stall_i,
  input  logic        w_valid_i,
  input  logic        w_load_i,
  input  logic        w_store_i,
  input  logic        w_rd_write_i,
  input  logic [2:0]  w_fun_i,
  input  logic [4:0]  w_rd_i,
  input  logic [1:0]  w_rd_source_i,
  input  logic [31:0] w_dm_addr_i,
  input  logic [31:0] w_rd_value_i,
  input  logic [31:0] w_rd_shifter_i,
  input  logic [31:0] w_rd_multiply_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic        w_stall_req_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        w_load_pending_o,
  output logic        w_bus_error_o
);

  wb_state_t   state, state_nxt;
  logic [4:0]  pend_rd;
  logic [2:0]  pend_fun;
  logic [1:0]  pend_addr;
  logic        pend_rd_write;
  logic        mem_load, mem_store, bus_err_set;
  logic [2:0]  al_fun;
  logic [1:0]  al_addr;
  logic [31:0] load_value, mul_value, rd_mux;
  logic        unused_addr;

  assign unused_addr = ^w_dm_addr_i[31:2];
  assign mem_load    = w_valid_i & w_load_i;
  assign mem_store   = w_valid_i & w_store_i;

  // Same-cycle completions in IDLE extract from live fields; otherwise from the captured access.
  assign al_fun  = (state == ST_IDLE) ? w_fun_i : pend_fun;
  assign al_addr = (state == ST_IDLE) ? w_dm_addr_i[1:0] : pend_addr;

  urv_load_align u_load_align (
    .fun   (al_fun),
    .addr  (al_addr),
    .data  (dm_data_l_i),
    .value (load_value)
  );

  generate
    if (g_with_multiply != 0) begin : g_mul
      assign mul_value = w_rd_multiply_i;
    end else begin : g_no_mul
      logic unused_mul;
      assign unused_mul = ^w_rd_multiply_i;
      assign mul_value  = '0;
    end
  endgenerate

  always_comb begin
    rd_mux = w_rd_value_i;
    case (w_rd_source_i)
      RD_SOURCE_ALU:      rd_mux = w_rd_value_i;
      RD_SOURCE_LOAD:     rd_mux = load_value;
      RD_SOURCE_SHIFTER:  rd_mux = w_rd_shifter_i;
      RD_SOURCE_MULTIPLY: rd_mux = mul_value;
      default:            rd_mux = w_rd_value_i;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    w_stall_req_o = 1'b0;
    bus_err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dm_load_done_i && !mem_load)   bus_err_set = 1'b1;
        if (dm_store_done_i && !mem_store) bus_err_set = 1'b1;
        if (mem_load) begin
          if (!dm_load_done_i) begin
            state_nxt     = ST_WAIT_LOAD;
            w_stall_req_o = 1'b1;
          end
        end else if (mem_store && !dm_store_done_i) begin
          state_nxt     = ST_WAIT_STORE;
          w_stall_req_o = 1'b1;
        end
      end
      ST_WAIT_LOAD: begin
        if (dm_store_done_i) bus_err_set = 1'b1;
        if (dm_load_done_i) state_nxt = ST_IDLE;
        else                w_stall_req_o = 1'b1;
      end
      ST_WAIT_STORE: begin
        if (dm_load_done_i) bus_err_set = 1'b1;
        if (dm_store_done_i) state_nxt = ST_IDLE;
        else                 w_stall_req_o = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign w_load_pending_o = (state == ST_WAIT_LOAD);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= ST_IDLE;
      pend_rd       <= '0;
      pend_fun      <= '0;
      pend_addr     <= '0;
      pend_rd_write <= 1'b0;
      w_bus_error_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus_err_set) w_bus_error_o <= 1'b1;
      if (state == ST_IDLE && state_nxt != ST_IDLE) begin
        pend_rd       <= w_rd_i;
        pend_fun      <= w_fun_i;
        pend_addr     <= w_dm_addr_i[1:0];
        pend_rd_write <= w_rd_write_i;
      end
    end
  end

  // Load retirement ignores x_stall_i: the pipeline is normally stalled on our own request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rf_rd_o       <= '0;
      rf_rd_value_o <= '0;
      rf_rd_write_o <= 1'b0;
    end else begin
      rf_rd_write_o <= 1'b0;
      if (state == ST_IDLE && mem_load && dm_load_done_i) begin
        rf_rd_o       <= w_rd_i;
        rf_rd_value_o <= load_value;
        rf_rd_write_o <= w_rd_write_i && (w_rd_i != 5'd0);
      end else if (state == ST_WAIT_LOAD && dm_load_done_i) begin
        rf_rd_o       <= pend_rd;
        rf_rd_value_o <= load_value;
        rf_rd_write_o <= pend_rd_write && (pend_rd != 5'd0);
      end else if (state == ST_IDLE && !mem_load && !mem_store && !x_stall_i) begin
        rf_rd_o       <= w_rd_i;
        rf_rd_value_o <= rd_mux;
        rf_rd_write_o <= w_rd_write_i && w_valid_i && (w_rd_i != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_urv_writeback.sv
// tb/tb_urv_writeback.sv - randomized and directed self-checking bench for urv_writeback
module tb_urv_writeback;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  urv_writeback_if ex ();

  logic        x_stall = 1'b0;
  logic        ld_done = 1'b0;
  logic        st_done = 1'b0;
  logic [31:0] dm_data = '0;
  logic        stall_req, rf_write, load_pending, bus_err;
  logic [4:0]  rf_rd;
  logic [31:0] rf_val;

  urv_writeback #(.g_with_multiply(1)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .x_stall_i        (x_stall),
    .w_valid_i        (ex.valid),
    .w_load_i         (ex.load),
    .w_store_i        (ex.store),
    .w_rd_write_i     (ex.rd_write),
    .w_fun_i          (ex.fun),
    .w_rd_i           (ex.rd),
    .w_rd_source_i    (ex.rd_source),
    .w_dm_addr_i      (ex.dm_addr),
    .w_rd_value_i     (ex.rd_value),
    .w_rd_shifter_i   (ex.rd_shifter),
    .w_rd_multiply_i  (ex.rd_multiply),
    .dm_data_l_i      (dm_data),
    .dm_load_done_i   (ld_done),
    .dm_store_done_i  (st_done),
    .w_stall_req_o    (stall_req),
    .rf_rd_o          (rf_rd),
    .rf_rd_value_o    (rf_val),
    .rf_rd_write_o    (rf_write),
    .w_load_pending_o (load_pending),
    .w_bus_error_o    (bus_err)
  );

  typedef struct {
    logic       is_load;
    logic [4:0] rd;
    logic [2:0] fun;
    logic [1:0] addr;
    logic       rd_write;
  } acc_t;

  acc_t        pend_q[$];
  acc_t        m_a;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_val = '0;
  logic        m_wr = 1'b0;
  logic        m_err = 1'b0;
  logic        m_ml, m_ms;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] extract(input logic [2:0] fun, input logic [1:0] addr,
                                          input logic [31:0] data);
    logic [31:0] b, h;
    b = (data >> (8 * addr)) & 32'hFF;
    h = (data >> (16 * addr[1])) & 32'hFFFF;
    case (fun)
      3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b101:  return h;
      3'b010:  return data;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_stall();
    if (pend_q.size() == 0)
      return (ex.valid && ex.load && !ld_done) ||
             (ex.valid && ex.store && !ex.load && !st_done);
    return pend_q[0].is_load ? !ld_done : !st_done;
  endfunction

  // Reference model: an outstanding-access queue plus the rf write it promises next cycle.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pend_q.delete();
      m_rd = '0; m_val = '0; m_wr = 1'b0; m_err = 1'b0;
    end else begin
      m_wr = 1'b0;
      if (pend_q.size() == 0) begin
        m_ml = ex.valid && ex.load;
        m_ms = ex.valid && ex.store;
        if (ld_done && !m_ml) m_err = 1'b1;
        if (st_done && !m_ms) m_err = 1'b1;
        m_a.rd = ex.rd; m_a.fun = ex.fun; m_a.addr = ex.dm_addr[1:0]; m_a.rd_write = ex.rd_write;
        if (m_ml) begin
          if (ld_done) begin
            m_rd = ex.rd;
            m_val = extract(ex.fun, ex.dm_addr[1:0], dm_data);
            m_wr = ex.rd_write && (ex.rd != 0);
          end else begin
            m_a.is_load = 1'b1;
            pend_q.push_back(m_a);
          end
        end else if (m_ms) begin
          if (!st_done) begin
            m_a.is_load = 1'b0;
            pend_q.push_back(m_a);
          end
        end else if (!x_stall) begin
          m_rd = ex.rd;
          case (ex.rd_source)
            2'd0:    m_val = ex.rd_value;
            2'd1:    m_val = extract(ex.fun, ex.dm_addr[1:0], dm_data);
            2'd2:    m_val = ex.rd_shifter;
            default: m_val = ex.rd_multiply;
          endcase
          m_wr = ex.rd_write && ex.valid && (ex.rd != 0);
        end
      end else if (pend_q[0].is_load) begin
        if (st_done) m_err = 1'b1;
        if (ld_done) begin
          m_rd = pend_q[0].rd;
          m_val = extract(pend_q[0].fun, pend_q[0].addr, dm_data);
          m_wr = pend_q[0].rd_write && (pend_q[0].rd != 0);
          void'(pend_q.pop_front());
        end
      end else begin
        if (ld_done) m_err = 1'b1;
        if (st_done) void'(pend_q.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("rf_write", 32'(rf_write), 32'(m_wr));
      if (m_wr) begin
        chk("rf_rd", 32'(rf_rd), 32'(m_rd));
        chk("rf_value", rf_val, m_val);
      end
      chk("stall_req", 32'(stall_req), 32'(exp_stall()));
      chk("load_pending", 32'(load_pending),
          32'(pend_q.size() != 0 && pend_q[0].is_load));
      chk("bus_error", 32'(bus_err), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex.valid = 1'b0; ex.load = 1'b0; ex.store = 1'b0; ex.rd_write = 1'b0;
    ex.fun = '0; ex.rd = '0; ex.rd_source = '0; ex.dm_addr = '0;
    ex.rd_value = '0; ex.rd_shifter = '0; ex.rd_multiply = '0;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [2:0] fun,
                        input logic [4:0] rd, input logic [31:0] addr);
    ex.valid = 1'b1; ex.load = ld; ex.store = st; ex.rd_write = 1'b1;
    ex.fun = fun; ex.rd = rd; ex.dm_addr = addr;
    ex.rd_source = ld ? 2'd1 : 2'd0;
  endtask

  int n_stall;
  int n_wr;

  initial begin
    idle();
    chk("model_lb", extract(3'b000, 2'd3, 32'h80FF_0000), 32'hFFFF_FF80);
    chk("model_lhu", extract(3'b101, 2'd2, 32'hBEEF_0000), 32'h0000_BEEF);
    chk("model_lh", extract(3'b001, 2'd0, 32'h0000_8001), 32'hFFFF_8001);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_rf_value", rf_val, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_load_pending", 32'(load_pending), 32'd0);
    rst_n = 1'b1;
    cyc();

    set_op(1'b0, 1'b0, 3'd0, 5'd5, 32'd0);
    ex.rd_value = 32'h1234;
    cyc();
    idle();
    chk("add_write", 32'(rf_write), 32'd1);
    chk("add_rd", 32'(rf_rd), 32'd5);
    chk("add_value", rf_val, 32'h1234);
    cyc();
    chk("add_one_cycle", 32'(rf_write), 32'd0);

    set_op(1'b1, 1'b0, 3'b000, 5'd7, 32'h103);
    dm_data = 32'h80FF_0000;
    ld_done = 1'b1;
    #1;
    chk("lb_no_stall", 32'(stall_req), 32'd0);
    cyc();
    ld_done = 1'b0;
    idle();
    chk("lb_write", 32'(rf_write), 32'd1);
    chk("lb_rd", 32'(rf_rd), 32'd7);
    chk("lb_value", rf_val, 32'hFFFF_FF80);

    set_op(1'b1, 1'b0, 3'b101, 5'd9, 32'h202);
    n_stall = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        ld_done = 1'b1;
        dm_data = 32'hBEEF_0000;
      end
      #1;
      if (stall_req) n_stall++;
      cyc();
      ld_done = 1'b0;
      if (i == 0) idle();
    end
    chk("lhu_stall_cycles", n_stall, 32'd3);
    chk("lhu_write", 32'(rf_write), 32'd1);
    chk("lhu_rd", 32'(rf_rd), 32'd9);
    chk("lhu_value", rf_val, 32'h0000_BEEF);

    set_op(1'b1, 1'b0, 3'b010, 5'd0, 32'h0);
    ld_done = 1'b1;
    cyc();
    ld_done = 1'b0;
    idle();
    chk("load_rd0_no_write", 32'(rf_write), 32'd0);

    set_op(1'b0, 1'b1, 3'b010, 5'd3, 32'h40);
    n_stall = 0;
    n_wr = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) st_done = 1'b1;
      #1;
      if (stall_req) n_stall++;
      cyc();
      st_done = 1'b0;
      if (rf_write) n_wr++;
      if (i == 0) idle();
    end
    cyc();
    if (rf_write) n_wr++;
    chk("store_stall_cycles", n_stall, 32'd2);
    chk("store_no_write", n_wr, 32'd0);

    ld_done = 1'b1;
    cyc();
    ld_done = 1'b0;
    chk("spurious_err", 32'(bus_err), 32'd1);
    repeat (5) cyc();
    chk("err_sticky", 32'(bus_err), 32'd1);

    set_op(1'b0, 1'b0, 3'd0, 5'd5, 32'd0);
    ex.rd_value = 32'h55;
    cyc();
    set_op(1'b1, 1'b0, 3'b010, 5'd4, 32'h0);
    cyc();
    idle();
    chk("wait_load_pending", 32'(load_pending), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("async_rst_rf_value", rf_val, 32'd0);
    chk("async_rst_write", 32'(rf_write), 32'd0);
    chk("async_rst_pending", 32'(load_pending), 32'd0);
    chk("async_rst_err", 32'(bus_err), 32'd0);
    chk("async_rst_stall", 32'(stall_req), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    ld_done = 1'b1;
    cyc();
    ld_done = 1'b0;
    chk("late_done_err", 32'(bus_err), 32'd1);

    for (int seg = 0; seg < 8; seg++) begin
      idle();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      for (int c = 0; c < 500; c++) begin
        int r;
        ld_done = 1'b0;
        st_done = 1'b0;
        x_stall = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 7);
        ex.valid = ($urandom_range(0, 4) != 0);
        ex.load = (r < 2);
        ex.store = (r == 2);
        ex.rd_write = ($urandom_range(0, 3) != 0);
        ex.fun = 3'($urandom);
        ex.rd = 5'($urandom);
        ex.rd_source = 2'($urandom);
        ex.dm_addr = $urandom;
        ex.rd_value = $urandom;
        ex.rd_shifter = $urandom;
        ex.rd_multiply = $urandom;
        dm_data = $urandom;
        if (pend_q.size() != 0) begin
          if ($urandom_range(0, 2) == 0) begin
            if (pend_q[0].is_load) ld_done = 1'b1;
            else st_done = 1'b1;
          end
        end else begin
          if (ex.valid && ex.load && $urandom_range(0, 2) == 0) ld_done = 1'b1;
          if (ex.valid && ex.store && $urandom_range(0, 2) == 0) st_done = 1'b1;
        end
        if ($urandom_range(0, 255) == 0) ld_done = 1'b1;
        if ($urandom_range(0, 255) == 0) st_done = 1'b1;
        cyc();
      end
    end
    ld_done = 1'b0;
    st_done = 1'b0;
    x_stall = 1'b0;
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
